// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer driving one shared WORD_W adder.
// Processes one word per clock, LSW first, chaining a registered carry.
module addsub_seq_ctrl #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic [WORD_W*NWORDS-1:0]   a,
  input  logic [WORD_W*NWORDS-1:0]   b,
  output logic [WORD_W-1:0]          add_x,
  output logic [WORD_W-1:0]          add_y,
  output logic                       add_cin,
  input  logic [WORD_W-1:0]          add_s,
  input  logic                       add_cout,
  output logic                       busy,
  output logic                       done,
  output logic [WORD_W*NWORDS-1:0]   result,
  output logic                       carry_out,
  output logic                       overflow
);

  localparam int OPW = WORD_W * NWORDS;
  localparam int IW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [OPW-1:0]  la;
  logic [OPW-1:0]  lb;
  logic            lsub;
  logic            last;
  logic            accept;

  assign last   = (idx == IW'(NWORDS - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = RUN;
      RUN:  if (last) nxt = DONE;
      DONE: nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Adder inputs are forced to zero outside RUN
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_x   = la[int'(idx)*WORD_W +: WORD_W];
      add_y   = lsub ? ~lb[int'(idx)*WORD_W +: WORD_W]
                     :  lb[int'(idx)*WORD_W +: WORD_W];
      add_cin = (idx == '0) ? lsub : carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      la        <= '0;
      lb        <= '0;
      lsub      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        la        <= a;
        lb        <= b;
        lsub      <= sub;
        idx       <= '0;
        carry     <= 1'b0;
        result    <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else if (state == RUN) begin
        result[int'(idx)*WORD_W +: WORD_W] <= add_s;
        carry <= add_cout;
        if (last) begin
          idx       <= '0;
          carry_out <= add_cout;
          overflow  <= (add_x[WORD_W-1] == add_y[WORD_W-1]) &&
                       (add_s[WORD_W-1] != add_x[WORD_W-1]);
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl with a behavioural adder.
// Directed vectors push expected results; a monitor checks on done.
module tb_addsub_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [15:0] add_x;
  logic [15:0] add_y;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        carry_out;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        o;
    int          dc;
  } exp_t;

  exp_t q[$];

  addsub_seq_ctrl #(.WORD_W(16), .NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {16'd0, add_cin};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.r);
        chk("carry_out", 64'(carry_out), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.o));
        chk("done_latency", 64'(cyc), 64'(e.dc));
      end
    end
  end

  task automatic issue(input logic [63:0] aa, input logic [63:0] bb,
                       input logic s, input logic [63:0] er,
                       input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a = aa; b = bb; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.r = er; e.c = ec; e.o = eo; e.dc = cyc + 4;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("timeout", 64'd1, 64'd0);
  endtask

  initial begin
    exp_t e;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_addx", 64'(add_x), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0);
    wait_idle();
    issue(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("sub_cin", 64'(add_cin), 64'd1);
    chk("sub_addy", 64'(add_y), 64'hFFFE);
    wait_idle();
    chk("idle_addy", 64'(add_y), 64'd0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    wait_idle();
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
          64'h0, 1'b1, 1'b0);
    wait_idle();

    // start pulse with new operands mid-RUN must be ignored
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
          64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start held through DONE: back-to-back ops
    @(negedge clk);
    a = 64'h8000_0000_0000_0000; b = 64'h1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    e.r = 64'h7FFF_FFFF_FFFF_FFFF; e.c = 1'b1; e.o = 1'b1; e.dc = cyc + 4;
    q.push_back(e);
    a = 64'h5; b = 64'h7;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    e.r = 64'hFFFF_FFFF_FFFF_FFFE; e.c = 1'b0; e.o = 1'b0; e.dc = cyc + 4;
    q.push_back(e);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_idle();

    // reset mid-operation aborts without done
    issue(64'h1111_2222_3333_4444, 64'h1, 1'b0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_add", {add_x, add_y, 31'd0, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
